// File: rtl/md_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : md_issue_queue
// Purpose  : In-order issue FIFO between E-stage decode and the multiply/
//            divide unit. Buffers mult/multu/div/divu/mtlo/mthi requests,
//            hands them to MD one at a time while MD is idle, and stalls the
//            front end on mfhi/mflo until all MD work has retired.
// Ports    : clk, reset_n            - clock, async active-low reset
//            in_valid/in_op/in_a1/in_a2 -> push request from E stage
//            in_ready                - queue not full
//            flush                   - drop every queued op
//            md_busy                 - MD countdown active
//            md_op/md_a1/md_a2       - op issued to MD this cycle (0 = none)
//            mf_req / mf_stall       - mfhi/mflo present / freeze front end
//            q_count                 - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module md_issue_queue #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [OP_W-1:0]          in_op,
    input  logic [31:0]              in_a1,
    input  logic [31:0]              in_a2,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     md_busy,
    output logic [OP_W-1:0]          md_op,
    output logic [31:0]              md_a1,
    output logic [31:0]              md_a2,
    input  logic                     mf_req,
    output logic                     mf_stall,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int             c_PTR_W  = $clog2(DEPTH);
    localparam int             c_CNT_W  = c_PTR_W + 1;
    localparam logic [OP_W-1:0] c_OP_MAX = OP_W'(6);

    logic [OP_W-1:0]    r_op [DEPTH];
    logic [31:0]        r_a1 [DEPTH];
    logic [31:0]        r_a2 [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_op_ok;
    logic w_push;
    logic w_issue;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));

    // Only real MD opcodes occupy a slot; anything else is silently dropped.
    assign w_op_ok = (in_op != '0) && (in_op <= c_OP_MAX);

    // in_ready looks only at the occupancy, never at a same-cycle pop.
    assign w_push  = in_valid & ~w_full & ~flush & w_op_ok;

    // Head is issued straight from registered state: a freshly pushed op
    // cannot reach MD before the following cycle.
    assign w_issue = ~w_empty & ~md_busy & ~flush;

    assign in_ready = ~w_full;
    assign q_count  = r_count;
    assign md_op    = w_issue ? r_op[r_rd_ptr] : '0;
    assign md_a1    = w_issue ? r_a1[r_rd_ptr] : '0;
    assign md_a2    = w_issue ? r_a2[r_rd_ptr] : '0;

    // Stall until nothing is queued, nothing is in MD and nothing is leaving
    // for MD this cycle.
    assign mf_stall = mf_req & (~w_empty | md_busy | w_issue);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i] <= '0;
                r_a1[i] <= '0;
                r_a2[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_op[r_wr_ptr] <= in_op;
                r_a1[r_wr_ptr] <= in_a1;
                r_a2[r_wr_ptr] <= in_a2;
                // DEPTH is a power of two, so the pointer wraps on overflow.
                r_wr_ptr       <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_issue) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_issue) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_issue_queue
// Purpose  : Self-checking bench for md_issue_queue. A table of per-cycle
//            input/expected-output records is applied in a loop, followed by
//            hand-written sequences for the long MD countdown and the
//            asynchronous mid-cycle reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_issue_queue;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_a1;
    logic [31:0] in_a2;
    logic        in_ready;
    logic        flush;
    logic        md_busy;
    logic [3:0]  md_op;
    logic [31:0] md_a1;
    logic [31:0] md_a2;
    logic        mf_req;
    logic        mf_stall;
    logic [2:0]  q_count;

    int errors = 0;
    int checks = 0;

    md_issue_queue #(.DEPTH(4), .OP_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_op    (in_op),
        .in_a1    (in_a1),
        .in_a2    (in_a2),
        .in_ready (in_ready),
        .flush    (flush),
        .md_busy  (md_busy),
        .md_op    (md_op),
        .md_a1    (md_a1),
        .md_a2    (md_a2),
        .mf_req   (mf_req),
        .mf_stall (mf_stall),
        .q_count  (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [31:0] a1;
        logic [31:0] a2;
        logic        fl;
        logic        busy;
        logic        mf;
        logic        e_rdy;
        logic [3:0]  e_op;
        logic [31:0] e_a1;
        logic [31:0] e_a2;
        logic        e_stall;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [3:0] op, logic [31:0] a1, logic [31:0] a2,
                                logic fl, logic busy, logic mf,
                                logic e_rdy, logic [3:0] e_op, logic [31:0] e_a1,
                                logic [31:0] e_a2, logic e_stall, logic [2:0] e_cnt);
        vec_t r;
        r.v = v; r.op = op; r.a1 = a1; r.a2 = a2;
        r.fl = fl; r.busy = busy; r.mf = mf;
        r.e_rdy = e_rdy; r.e_op = e_op; r.e_a1 = e_a1; r.e_a2 = e_a2;
        r.e_stall = e_stall; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a1,
                         input logic [31:0] a2, input logic fl, input logic busy,
                         input logic mf);
        in_valid = v;
        in_op    = op;
        in_a1    = a1;
        in_a2    = a2;
        flush    = fl;
        md_busy  = busy;
        mf_req   = mf;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 4'd0, 0, 0, 0, 0, 1);

        //             v op   a1     a2            fl bz mf   rdy eop ea1  ea2           st cnt
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(1, 1,  3,  32'hFFFFFFFC, 0, 0, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 1, 3,   32'hFFFFFFFC, 0, 1));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        // illegal / invalid pushes are dropped
        vecs.push_back(mk(1, 0,  9,  9,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(1, 7,  9,  9,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(1, 15, 9,  9,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(0, 1,  5,  5,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        // fill while MD busy, fifth push ignored
        vecs.push_back(mk(1, 3,  10, 11,           0, 1, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(1, 4,  20, 21,           0, 1, 0,   1, 0, 0,   0,            0, 1));
        vecs.push_back(mk(1, 5,  30, 31,           0, 1, 0,   1, 0, 0,   0,            0, 2));
        vecs.push_back(mk(1, 6,  40, 41,           0, 1, 0,   1, 0, 0,   0,            0, 3));
        vecs.push_back(mk(1, 1,  50, 51,           0, 1, 0,   0, 0, 0,   0,            0, 4));
        vecs.push_back(mk(0, 0,  0,  0,            0, 1, 1,   0, 0, 0,   0,            1, 4));
        // pop from full: push in the same cycle still refused
        vecs.push_back(mk(1, 2,  60, 61,           0, 0, 0,   0, 3, 10,  11,           0, 4));
        vecs.push_back(mk(1, 2,  60, 61,           0, 1, 0,   1, 0, 0,   0,            0, 3));
        // drain across the pointer wrap, order preserved
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   0, 4, 20,  21,           0, 4));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 5, 30,  31,           0, 3));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 6, 40,  41,           0, 2));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 1,   1, 2, 60,  61,           1, 1));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 1,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(0, 0,  0,  0,            0, 1, 1,   1, 0, 0,   0,            1, 0));
        // simultaneous push and pop
        vecs.push_back(mk(1, 5,  70, 71,           0, 0, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(1, 6,  80, 81,           0, 0, 0,   1, 5, 70,  71,           0, 1));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 6, 80,  81,           0, 1));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        // flush with two queued ops; concurrent push lost
        vecs.push_back(mk(1, 1,  1,  2,            0, 1, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(1, 2,  3,  4,            0, 1, 0,   1, 0, 0,   0,            0, 1));
        vecs.push_back(mk(1, 3,  5,  6,            1, 0, 0,   1, 0, 0,   0,            0, 2));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        // mfhi behind a single MTHI
        vecs.push_back(mk(1, 6,  9,  0,            0, 0, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 1,   1, 6, 9,   0,            1, 1));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 1,   1, 0, 0,   0,            0, 0));
        // consecutive mt ops issue on consecutive cycles
        vecs.push_back(mk(1, 5,  7,  0,            0, 1, 0,   1, 0, 0,   0,            0, 0));
        vecs.push_back(mk(1, 6,  8,  0,            0, 1, 0,   1, 0, 0,   0,            0, 1));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 5, 7,   0,            0, 2));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 6, 8,   0,            0, 1));
        vecs.push_back(mk(0, 0,  0,  0,            0, 0, 0,   1, 0, 0,   0,            0, 0));

        // Reset state, observed while reset is held
        #12;
        check("rst_count", 32'(q_count), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_md_op", 32'(md_op), 0);
        check("rst_stall", 32'(mf_stall), 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].op, vecs[i].a1, vecs[i].a2,
                  vecs[i].fl, vecs[i].busy, vecs[i].mf);
            #1;
            check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d_md_op", i), 32'(md_op),    32'(vecs[i].e_op));
            check($sformatf("v%0d_md_a1", i), md_a1,         vecs[i].e_a1);
            check($sformatf("v%0d_md_a2", i), md_a2,         vecs[i].e_a2);
            check($sformatf("v%0d_stall", i), 32'(mf_stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_count", i), 32'(q_count),  32'(vecs[i].e_cnt));
        end

        // DIV then MULTU; MD busy for 10 cycles after the DIV issue
        @(negedge clk); drive(1, 4'd3, 100, 101, 0, 0, 0); #1;
        check("div_push_md_op", 32'(md_op), 0);
        @(negedge clk); drive(1, 4'd2, 200, 201, 0, 0, 0); #1;
        check("div_issue_op", 32'(md_op), 3);
        check("div_issue_a1", md_a1, 100);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); drive(0, 4'd0, 0, 0, 0, 1, 0); #1;
            check($sformatf("div_wait%0d_op", k), 32'(md_op), 0);
            check($sformatf("div_wait%0d_cnt", k), 32'(q_count), 1);
        end
        @(negedge clk); drive(0, 4'd0, 0, 0, 0, 0, 0); #1;
        check("multu_issue_op", 32'(md_op), 2);
        check("multu_issue_a1", md_a1, 200);
        check("multu_issue_a2", md_a2, 201);
        @(negedge clk); #1;
        check("multu_done_cnt", 32'(q_count), 0);

        // Asynchronous reset mid-cycle with three ops queued
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1, 4'(k + 1), 32'(k), 32'(k), 0, 1, 0);
        end
        @(negedge clk); drive(0, 4'd0, 0, 0, 0, 0, 1); #1;
        check("pre_rst_cnt", 32'(q_count), 3);
        check("pre_rst_op", 32'(md_op), 1);
        check("pre_rst_stall", 32'(mf_stall), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(q_count), 0);
        check("async_rst_op", 32'(md_op), 0);
        check("async_rst_a1", md_a1, 0);
        check("async_rst_ready", 32'(in_ready), 1);
        check("async_rst_stall", 32'(mf_stall), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_cnt", 32'(q_count), 0);
        check("post_rst_op", 32'(md_op), 0);
        check("post_rst_stall", 32'(mf_stall), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
